muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit; extends the single-cycle ALU op set with MUL, MULH, DIV and REM.
//   Signed and unsigned modes; iterative radix-2 datapath (shift-add multiply, restoring divide).
//   Sits beside the ALU in EX; the pipeline stalls while ready=0 and consumes out/flags on done.
//   Flags have the same meaning as the ALU flags.
// PARAMETERS
//   WIDTH      32  operand/result width in bits (>=4)
//   FAST_ZERO  1   1: divide-by-zero and signed MIN/-1 complete in 1 cycle; 0: full WIDTH-cycle latency
// PORTS
//   CLK       in   1      clock, rising edge
//   RST       in   1      asynchronous reset, active-high
//   start     in   1      request; accepted only on an edge where ready=1
//   flush     in   1      abort in-flight op; no done is produced for it
//   ops       in   2      00 MUL(low word), 01 MULH(high word), 10 DIV, 11 REM
//   is_signed in   1      1: operands are two's complement (applies to both operands)
//   a         in   WIDTH  multiplicand / dividend
//   b         in   WIDTH  multiplier / divisor
//   ready     out  1      idle or done; can accept start
//   done      out  1      one-cycle pulse; out/flags valid from this cycle
//   out       out  WIDTH  result; held until the next done
//   negative  out  1      out[WIDTH-1]
//   overflow  out  1      signed DIV of MIN by -1 only; 0 otherwise
//   zero      out  1      out == 0
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; ready=1; done=0; out=0; negative=0; overflow=0; zero=1.
//   FSM IDLE -> CALC on accepted start; CALC -> DONE after WIDTH iterations; DONE -> IDLE, or DONE -> CALC if start.
//   Accept: a, b, ops and is_signed are latched on the accepting edge. Later input changes have no effect.
//   Signed mode: operands are converted to magnitudes before the loop. Result sign is applied on CALC->DONE.
//     MUL/MULH sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sign of dividend. Division truncates toward zero.
//   Multiply: 2*WIDTH product register. MUL returns bits [WIDTH-1:0]; MULH returns bits [2W-1:W].
//   Latency: done is high exactly WIDTH+1 cycles after the accepting edge.
//     ready=0 during CALC; ready=1 in DONE (back-to-back start is allowed there).
//   Divide-by-zero: DIV -> all ones; REM -> a. overflow=0.
//     With FAST_ZERO=1, done is high 1 cycle after accept.
//   Signed MIN/-1: DIV -> MIN, overflow=1; REM -> 0, overflow=0.
//     With FAST_ZERO=1, done is high 1 cycle after accept.
//   out and flags are updated only in the done cycle; they hold until the next done. done never asserts in IDLE or CALC.
//   start while ready=0: ignored, with no queueing.
//   flush: has priority over start in the same cycle. Next state=IDLE, ready=1, no done.
//     out and flags keep their previous values. Flush in IDLE or DONE only clears done.
//   Iteration counter spans 0..WIDTH. There is no wrap; the counter is cleared on accept.
// TESTING (WIDTH=32)
//   1. Reset, then unsigned MUL a=7 b=6 -> done exactly 33 cycles after accept; out=0x0000002A, zero=0, neg=0.
//   2. Signed MULH a=-2 b=3 -> out=0xFFFFFFFF, neg=1. Unsigned MULH a=b=0xFFFFFFFF -> out=0xFFFFFFFE.
//   3. Signed DIV a=-7 b=2 -> out=0xFFFFFFFD.
//      Signed REM on the same operands -> out=0xFFFFFFFF. Unsigned DIV 100/7 -> 14.
//   4. DIV 5/0 -> out=0xFFFFFFFF, done 1 cycle after accept. REM 5/0 -> 5.
//      Signed DIV 0x80000000/-1 -> 0x80000000 with ovf=1. Repeat with FAST_ZERO=0 -> latency 33.
//   5. Accept DIV; start again at cycle 5 (ignored); flush at cycle 10 -> ready=1 next cycle, no done, out unchanged.
//   6. Assert RST mid-CALC, asynchronously -> outputs take reset values immediately.
//      Back-to-back start in the DONE cycle -> second done 33 cycles later.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface muldiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [1:0]       ops;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             negative;
   logic             overflow;
   logic             zero;

   modport master (
      output start, flush, ops, is_signed, a, b,
      input  ready, done, out, negative, overflow, zero
   );

   modport slave (
      input  start, flush, ops, is_signed, a, b,
      output ready, done, out, negative, overflow, zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide, signed via
// magnitudes with the result sign applied on completion.
module muldiv_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          FAST_ZERO = 1'b1
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   localparam int unsigned      CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opd_q, opd_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [1:0]       op_q, op_d;
   logic             sgn_res_q, sgn_res_d;
   logic             sgn_a_q, sgn_a_d;
   logic             dz_q, dz_d;
   logic             mo_q, mo_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             ovf_q, ovf_d;

   // Operand conditioning for the accepting edge
   logic             sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      sa    = bus.is_signed & bus.a[WIDTH-1];
      sb    = bus.is_signed & bus.b[WIDTH-1];
      mag_a = sa ? -bus.a : bus.a;
      mag_b = sb ? -bus.b : bus.b;
   end

   // One radix-2 step of each datapath
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_ge   = div_sh >= {1'b0, opd_q};
      // The true difference is below the divisor, so the low WIDTH bits are exact.
      div_diff = div_sh[WIDTH-1:0] - opd_q;
   end

   // Final result with signs and corner cases applied
   logic [2*WIDTH-1:0] prod_full;
   logic [WIDTH-1:0]   quo, rmd, res;
   logic               res_ovf;

   always_comb begin
      prod_full = sgn_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      quo       = sgn_res_q ? -lo_q : lo_q;
      rmd       = sgn_a_q ? -hi_q : hi_q;
      res_ovf   = 1'b0;
      unique case (op_q)
         2'b00:   res = prod_full[WIDTH-1:0];
         2'b01:   res = prod_full[2*WIDTH-1:WIDTH];
         2'b10:   res = quo;
         default: res = rmd;
      endcase
      if (dz_q) begin
         res = op_q[0] ? a_q : '1;
      end else if (mo_q) begin
         res     = op_q[0] ? '0 : MIN_VAL;
         res_ovf = ~op_q[0];
      end
   end

   logic accept, finish, fast_done;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      opd_d     = opd_q;
      a_d       = a_q;
      op_d      = op_q;
      sgn_res_d = sgn_res_q;
      sgn_a_d   = sgn_a_q;
      dz_d      = dz_q;
      mo_d      = mo_q;
      out_d     = out_q;
      ovf_d     = ovf_q;
      accept    = 1'b0;
      finish    = 1'b0;
      fast_done = FAST_ZERO && (dz_q || mo_q);

      unique case (state_q)
         StIdle: begin
            if (!bus.flush && bus.start) begin
               accept = 1'b1;
            end
         end
         StCalc: begin
            if (bus.flush) begin
               state_d = StIdle;
            end else if (cnt_q == CNT_LAST || fast_done) begin
               finish = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (op_q[1]) begin
                  hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], div_ge};
               end else begin
                  hi_d = mul_sum[WIDTH:1];
                  lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
               end
            end
         end
         StDone: begin
            if (!bus.flush && bus.start) begin
               accept = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         state_d   = StCalc;
         cnt_d     = '0;
         hi_d      = '0;
         lo_d      = bus.ops[1] ? mag_a : mag_b;
         opd_d     = bus.ops[1] ? mag_b : mag_a;
         a_d       = bus.a;
         op_d      = bus.ops;
         sgn_res_d = sa ^ sb;
         sgn_a_d   = sa;
         dz_d      = bus.ops[1] && (bus.b == '0);
         mo_d      = bus.ops[1] && bus.is_signed && (bus.a == MIN_VAL) && (bus.b == '1);
      end

      if (finish) begin
         state_d = StDone;
         out_d   = res;
         ovf_d   = res_ovf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opd_q     <= '0;
         a_q       <= '0;
         op_q      <= 2'b00;
         sgn_res_q <= 1'b0;
         sgn_a_q   <= 1'b0;
         dz_q      <= 1'b0;
         mo_q      <= 1'b0;
         out_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         opd_q     <= opd_d;
         a_q       <= a_d;
         op_q      <= op_d;
         sgn_res_q <= sgn_res_d;
         sgn_a_q   <= sgn_a_d;
         dz_q      <= dz_d;
         mo_q      <= mo_d;
         out_q     <= out_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.ready    = (state_q != StCalc);
   assign bus.done     = (state_q == StDone);
   assign bus.out      = out_q;
   assign bus.negative = out_q[WIDTH-1];
   assign bus.overflow = ovf_q;
   assign bus.zero     = (out_q == '0);
endmodule
